// File: rtl/spi_initiator_tx_pkg.sv
// Shared types and constants for the icepool SPI initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icepool_spi_pkg;

   localparam int DEFAULT_WORD_WIDTH = 32;

   // A responder with a 3-stage sck synchroniser needs at least this many
   // clk_in cycles of high phase to see and act on the rising edge.
   localparam int MIN_CLK_DIV = 4;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCK_LOW,
      SCK_HIGH,
      HOLD,
      DONE
   } spi_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_initiator_tx_if.sv
// Word handshake and SPI pin bundle between host logic, the initiator and the bus.
// Latency: n/a (wires only).
// Backpressure: tx_valid_in/tx_ready_out handshake; SPI pins have none.
interface spi_initiator_tx_if
   import icepool_spi_pkg::*;
#(
   parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) ();

   logic [WORD_WIDTH-1:0] tx_data_in;
   logic                  tx_valid_in;
   logic                  tx_ready_out;
   logic [WORD_WIDTH-1:0] rx_data_out;
   logic                  rx_valid_out;
   logic                  busy_out;
   logic                  sck_out;
   logic                  sdo_out;
   logic                  sdi_in;
   logic                  cs_n_out;

   // master: the initiator itself (drives SPI pins, consumes tx words)
   modport master (
      input  tx_data_in, tx_valid_in, sdi_in,
      output tx_ready_out, rx_data_out, rx_valid_out, busy_out,
             sck_out, sdo_out, cs_n_out
   );

   // slave: host logic plus the responder side of the pins
   modport slave (
      output tx_data_in, tx_valid_in, sdi_in,
      input  tx_ready_out, rx_data_out, rx_valid_out, busy_out,
             sck_out, sdo_out, cs_n_out
   );

endinterface

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Latency: a load of N gives tc N cycles later, so a phase lasts N+1 cycles.
// Backpressure: none; a load always wins over counting.
module spi_half_period_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count;

   // Count down to zero and park there until the next load.
   always_ff @(posedge clk_in) begin
      if (reset_in)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - ONE;
   end

   assign tc = (count == '0);

endmodule

// File: rtl/spi_initiator_tx.sv
// SPI mode-0 initiator: shifts one word out MSB-first on sdo while capturing sdi.
// Latency: 1 + CS_SETUP + WORD_WIDTH*2*CLK_DIV + CS_HOLD cycles from accept to rx_valid.
// Backpressure: tx_ready only in IDLE, no queueing; a held tx_valid is taken on the first IDLE cycle.
module spi_initiator_tx
   import icepool_spi_pkg::*;
#(
   parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
   parameter int CLK_DIV    = 4,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 2
) (
   input logic                clk_in,
   input logic                reset_in,
   spi_initiator_tx_if.master bus
);

   localparam int TW = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);
   localparam int BW = $clog2(WORD_WIDTH + 1);

   localparam logic [TW-1:0] SETUP_LD = TW'(CS_SETUP - 1);
   localparam logic [TW-1:0] DIV_LD   = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] HOLD_LD  = TW'(CS_HOLD - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   localparam logic [BW-1:0] BIT_ALL  = BW'(WORD_WIDTH);

   if (CLK_DIV < MIN_CLK_DIV) begin : g_chk_div
      $error("spi_initiator_tx: CLK_DIV=%0d is below the minimum of %0d", CLK_DIV, MIN_CLK_DIV);
   end
   if (CS_SETUP < 1 || CS_HOLD < 1 || WORD_WIDTH < 2) begin : g_chk_misc
      $error("spi_initiator_tx: CS_SETUP/CS_HOLD must be >= 1 and WORD_WIDTH >= 2");
   end

   spi_state_t            state;
   logic [WORD_WIDTH-1:0] tx_sr;
   logic [WORD_WIDTH-1:0] rx_sr;
   logic [WORD_WIDTH-1:0] rx_data;
   logic [BW-1:0]         bit_cnt;
   logic                  tx_ready;
   logic                  busy;
   logic                  rx_valid;
   logic                  sck;
   logic                  cs_n;
   logic                  sdi_meta;
   logic                  sdi_sync;
   logic                  accept;
   logic                  tmr_load;
   logic [TW-1:0]         tmr_val;
   logic                  tmr_tc;

   assign accept = bus.tx_valid_in && tx_ready;

   // sdi comes from another board with no timing relationship to clk_in.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         sdi_meta <= 1'b0;
         sdi_sync <= 1'b0;
      end else begin
         sdi_meta <= bus.sdi_in;
         sdi_sync <= sdi_meta;
      end
   end

   // Reload the phase timer whenever the FSM moves into a timed phase.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         IDLE:     if (accept) begin tmr_load = 1'b1; tmr_val = SETUP_LD; end
         SETUP:    if (tmr_tc) begin tmr_load = 1'b1; tmr_val = DIV_LD;   end
         SCK_LOW:  if (tmr_tc) begin tmr_load = 1'b1; tmr_val = DIV_LD;   end
         SCK_HIGH: if (tmr_tc) begin
                      tmr_load = 1'b1;
                      tmr_val  = (bit_cnt == BIT_ONE) ? HOLD_LD : DIV_LD;
                   end
         default:  ;
      endcase
   end

   spi_half_period_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   // Transaction sequencer; every bus-facing output is a register here.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state    <= IDLE;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rx_data  <= '0;
         bit_cnt  <= '0;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
         rx_valid <= 1'b0;
         sck      <= 1'b0;
         cs_n     <= 1'b1;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               tx_sr    <= bus.tx_data_in;
               bit_cnt  <= BIT_ALL;
               cs_n     <= 1'b0;
               busy     <= 1'b1;
               tx_ready <= 1'b0;
               state    <= SETUP;
            end
            SETUP: if (tmr_tc) state <= SCK_LOW;
            SCK_LOW: if (tmr_tc) begin
               // Rising edge: sdi has been stable for the whole low phase.
               sck   <= 1'b1;
               rx_sr <= {rx_sr[WORD_WIDTH-2:0], sdi_sync};
               state <= SCK_HIGH;
            end
            SCK_HIGH: if (tmr_tc) begin
               sck     <= 1'b0;
               bit_cnt <= bit_cnt - BIT_ONE;
               if (bit_cnt == BIT_ONE) begin
                  state <= HOLD;
               end else begin
                  tx_sr <= {tx_sr[WORD_WIDTH-2:0], 1'b0};
                  state <= SCK_LOW;
               end
            end
            HOLD: if (tmr_tc) begin
               cs_n     <= 1'b1;
               busy     <= 1'b0;
               rx_valid <= 1'b1;
               rx_data  <= rx_sr;
               state    <= DONE;
            end
            DONE: begin
               // Ready only rises after DONE so cs_n is high for at least a cycle.
               tx_ready <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.tx_ready_out = tx_ready;
   assign bus.rx_data_out  = rx_data;
   assign bus.rx_valid_out = rx_valid;
   assign bus.busy_out     = busy;
   assign bus.sck_out      = sck;
   assign bus.sdo_out      = tx_sr[WORD_WIDTH-1];
   assign bus.cs_n_out     = cs_n;

endmodule

// File: tb/tb_spi_initiator_tx.sv
// Directed bench for spi_initiator_tx: default instance plus a CLK_DIV=6/CS_SETUP=3 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_initiator_tx;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_initiator_tx_if #(.WORD_WIDTH(32)) if0 ();
   spi_initiator_tx_if #(.WORD_WIDTH(32)) if1 ();

   spi_initiator_tx #(.WORD_WIDTH(32), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) u0 (
      .clk_in   (clk),
      .reset_in (rst),
      .bus      (if0.master)
   );

   spi_initiator_tx #(.WORD_WIDTH(32), .CLK_DIV(6), .CS_SETUP(3), .CS_HOLD(2)) u1 (
      .clk_in   (clk),
      .reset_in (rst),
      .bus      (if1.master)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // 32-bit shift-register responder, sck synchronised through 3 flops
   logic [31:0] resp_sr   = '0;
   logic [2:0]  resp_sync = '0;
   logic        resp_en   = 1'b0;
   always @(negedge clk) begin
      resp_sync = {resp_sync[1:0], if0.sck_out};
      if (!if0.cs_n_out && resp_sync[1] && !resp_sync[2])
         resp_sr = {resp_sr[30:0], if0.sdo_out};
      if0.sdi_in = resp_en ? resp_sr[31] : 1'b1;
   end

   // monitor state, updated only inside step()
   int cyc = 0;
   int rises0, rxv0, rxv0_cyc, acc0_cyc, cs_low0, rdy_low0, rdy_in_txn0;
   int cs_falls0, gap0, min_gap0;
   logic acc0_seen, sck0_q, cs0_q, done_cs0, done_busy0;
   logic [31:0] sdo0_word;
   int rises1, rxv1, rxv1_cyc, acc1_cyc, cs_fall1, first_rise1, last_edge1, hp_min1, hp_max1;
   logic acc1_seen, sck1_q, cs1_q, seen_rise1;
   logic [31:0] sdo1_word;

   task automatic clr0();
      rises0 = 0; rxv0 = 0; rxv0_cyc = 0; acc0_cyc = 0; cs_low0 = 0; rdy_low0 = 0;
      rdy_in_txn0 = 0; cs_falls0 = 0; gap0 = 0; min_gap0 = 1000; acc0_seen = 0;
      sck0_q = 1'b0; cs0_q = 1'b1; sdo0_word = '0; done_cs0 = 1'b0; done_busy0 = 1'b1;
   endtask

   task automatic clr1();
      rises1 = 0; rxv1 = 0; rxv1_cyc = 0; acc1_cyc = 0; cs_fall1 = 0; first_rise1 = 0;
      last_edge1 = 0; hp_min1 = 1000; hp_max1 = 0; acc1_seen = 0;
      sck1_q = 1'b0; cs1_q = 1'b1; seen_rise1 = 1'b0; sdo1_word = '0;
   endtask

   task automatic step();
      int hp;
      if (if0.tx_valid_in && if0.tx_ready_out) begin acc0_cyc = cyc; acc0_seen = 1'b1; end
      if (if1.tx_valid_in && if1.tx_ready_out) begin acc1_cyc = cyc; acc1_seen = 1'b1; end
      @(negedge clk);
      cyc++;
      if (if0.sck_out && !sck0_q) begin rises0++; sdo0_word = {sdo0_word[30:0], if0.sdo_out}; end
      sck0_q = if0.sck_out;
      if (if0.rx_valid_out) begin
         rxv0++; rxv0_cyc = cyc; done_cs0 = if0.cs_n_out; done_busy0 = if0.busy_out;
      end
      if (!if0.cs_n_out) cs_low0++;
      if (!if0.tx_ready_out) rdy_low0++;
      if (!if0.cs_n_out && if0.tx_ready_out) rdy_in_txn0++;
      if (cs0_q && !if0.cs_n_out) begin
         cs_falls0++;
         if (cs_falls0 > 1 && gap0 < min_gap0) min_gap0 = gap0;
      end
      if (if0.cs_n_out) gap0++; else gap0 = 0;
      cs0_q = if0.cs_n_out;
      if (if1.sck_out != sck1_q) begin
         if (seen_rise1) begin
            hp = cyc - last_edge1;
            if (hp < hp_min1) hp_min1 = hp;
            if (hp > hp_max1) hp_max1 = hp;
         end else if (if1.sck_out) begin
            first_rise1 = cyc; seen_rise1 = 1'b1;
         end
         last_edge1 = cyc;
         if (if1.sck_out) begin rises1++; sdo1_word = {sdo1_word[30:0], if1.sdo_out}; end
      end
      sck1_q = if1.sck_out;
      if (cs1_q && !if1.cs_n_out) cs_fall1 = cyc;
      cs1_q = if1.cs_n_out;
      if (if1.rx_valid_out) begin rxv1++; rxv1_cyc = cyc; end
   endtask

   task automatic send0(input logic [31:0] d);
      int n;
      n = 0;
      acc0_seen = 1'b0;
      if0.tx_data_in = d; if0.tx_valid_in = 1'b1;
      while (!acc0_seen && n < 50) begin step(); n++; end
      if0.tx_valid_in = 1'b0;
      chk("accept0", acc0_seen, 1'b1);
   endtask

   task automatic wait_rx0(input int limit);
      int n, start;
      n = 0; start = rxv0;
      while (rxv0 == start && n < limit) begin step(); n++; end
      chk("done0_seen", rxv0 != start, 1'b1);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      if0.tx_valid_in = 1'b0; if0.tx_data_in = '0;
      if1.tx_valid_in = 1'b0; if1.tx_data_in = '0; if1.sdi_in = 1'b0;
      clr0(); clr1();
      repeat (3) step();

      // reset values
      chk("rst_ready",  if0.tx_ready_out, 1'b1);
      chk("rst_busy",   if0.busy_out,     1'b0);
      chk("rst_rxv",    if0.rx_valid_out, 1'b0);
      chk("rst_rxdata", if0.rx_data_out,  32'h0);
      chk("rst_sck",    if0.sck_out,      1'b0);
      chk("rst_sdo",    if0.sdo_out,      1'b0);
      chk("rst_csn",    if0.cs_n_out,     1'b1);

      // idle 20 cycles
      rst = 1'b0;
      clr0();
      repeat (20) step();
      chk("idle_rxv",     rxv0,     0);
      chk("idle_cs_low",  cs_low0,  0);
      chk("idle_sck",     rises0,   0);
      chk("idle_rdy_low", rdy_low0, 0);

      // single word, sdi tied high
      clr0();
      send0(32'hA5A5_0F0F);
      wait_rx0(400);
      repeat (3) step();
      chk("a5_rises",    rises0,              32);
      chk("a5_sdo",      sdo0_word,           32'hA5A5_0F0F);
      chk("a5_rxdata",   if0.rx_data_out,     32'hFFFF_FFFF);
      chk("a5_rxv_len",  rxv0,                1);
      chk("a5_latency",  rxv0_cyc - acc0_cyc, 261);
      chk("a5_done_csn", done_cs0,            1'b1);
      chk("a5_done_bsy", done_busy0,          1'b0);

      // responder loopback: each word returns the previous one
      resp_en = 1'b1;
      step();
      send0(32'h1234_5678);
      wait_rx0(400);
      chk("lb1_rxdata", if0.rx_data_out, 32'hA5A5_0F0F);
      send0(32'hDEAD_BEEF);
      wait_rx0(400);
      chk("lb2_rxdata", if0.rx_data_out, 32'h1234_5678);
      chk("lb2_resp",   resp_sr,         32'hDEAD_BEEF);

      // tx_valid held for three words
      repeat (2) step();
      clr0();
      if0.tx_data_in = 32'h3C3C_C3C3; if0.tx_valid_in = 1'b1;
      n = 0;
      while (rxv0 < 3 && n < 1200) begin step(); n++; end
      if0.tx_valid_in = 1'b0;
      repeat (5) step();
      chk("b2b_words",  rxv0,            3);
      chk("b2b_cs_win", cs_falls0,       3);
      chk("b2b_gap",    min_gap0,        2);
      chk("b2b_rdy",    rdy_in_txn0,     0);
      chk("b2b_rxdata", if0.rx_data_out, 32'h3C3C_C3C3);

      // reset in the middle of a transaction
      clr0();
      send0(32'h5555_AAAA);
      repeat (98) step();
      chk("mid_pre_csn", if0.cs_n_out, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_csn",   if0.cs_n_out,     1'b1);
      chk("mid_sck",   if0.sck_out,      1'b0);
      chk("mid_ready", if0.tx_ready_out, 1'b1);
      chk("mid_rxv",   if0.rx_valid_out, 1'b0);
      clr0();
      repeat (300) step();
      chk("mid_no_rxv", rxv0,    0);
      chk("mid_no_cs",  cs_low0, 0);

      // CLK_DIV=6, CS_SETUP=3 instance, sdi tied low
      clr1();
      if1.tx_data_in = 32'hC35A_0FF0; if1.tx_valid_in = 1'b1;
      n = 0;
      while (!acc1_seen && n < 50) begin step(); n++; end
      if1.tx_valid_in = 1'b0;
      chk("d6_accept", acc1_seen, 1'b1);
      n = 0;
      while (rxv1 == 0 && n < 600) begin step(); n++; end
      chk("d6_first_rise", first_rise1 - cs_fall1, 9);
      chk("d6_hp_min",     hp_min1,                6);
      chk("d6_hp_max",     hp_max1,                6);
      chk("d6_rises",      rises1,                 32);
      chk("d6_sdo",        sdo1_word,              32'hC35A_0FF0);
      chk("d6_rxdata",     if1.rx_data_out,        32'h0);
      chk("d6_latency",    rxv1_cyc - acc1_cyc,    390);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
